// File: rtl/store_addr_prefetch_fifo_if.sv
// Handshake bundle for store_addr_prefetch_fifo: write side, FWFT read side and status.
// The optional peak-occupancy signal exists only when STORE_ADDR_FIFO_PEAK_EN is defined.
interface store_addr_prefetch_fifo_if #(
  parameter int DATA_WIDTH  = 4,
  parameter int DEPTH_WIDTH = 11
);
  logic                   flush;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   wr_vld;
  logic                   afull;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   rd_vld;
  logic [DEPTH_WIDTH:0]   count;
  logic                   ovf;
  logic                   udf;
`ifdef STORE_ADDR_FIFO_PEAK_EN
  logic [DEPTH_WIDTH:0]   peak;
`endif

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_vld, afull, rd_data, rd_vld, count, ovf, udf
`ifdef STORE_ADDR_FIFO_PEAK_EN
    , input peak
`endif
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_vld, afull, rd_data, rd_vld, count, ovf, udf
`ifdef STORE_ADDR_FIFO_PEAK_EN
    , output peak
`endif
  );
endinterface

// File: rtl/store_addr_prefetch_fifo.sv
// First-word-fall-through FIFO: registered-read RAM, one RAM read register and one prefetch output register.
// Optional macro STORE_ADDR_FIFO_PEAK_EN adds a peak-occupancy output.
module store_addr_prefetch_fifo #(
  parameter int DATA_WIDTH  = 4,
  parameter int DEPTH_WIDTH = 11,
  parameter int AFULL_TH    = 2**DEPTH_WIDTH - 4
) (
  input  logic                       clk,
  input  logic                       rst,
  store_addr_prefetch_fifo_if.slave  bus
);
  typedef logic [DEPTH_WIDTH:0]   cnt_t;
  typedef logic [DEPTH_WIDTH-1:0] ptr_t;

  localparam int   DEPTH   = 2**DEPTH_WIDTH;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C = cnt_t'(AFULL_TH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mid_data_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  ptr_t wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d, ram_cnt;
  logic mid_vld_q, mid_vld_d, rd_vld_q, rd_vld_d;
  logic wr_vld_q, wr_vld_d, afull_q, afull_d;
  logic ovf_q, ovf_d, udf_q, udf_d;
  logic do_wr, do_pop, out_load, ram_rd;

  // count covers RAM, the read register and the output register, so the RAM-only
  // occupancy is what remains after removing the two valid stages.
  always_comb begin
    do_wr     = bus.wr_en && wr_vld_q;
    do_pop    = bus.rd_en && rd_vld_q;
    ram_cnt   = count_q - cnt_t'(mid_vld_q) - cnt_t'(rd_vld_q);
    out_load  = !rd_vld_q || do_pop;
    ram_rd    = (ram_cnt != '0) && (!mid_vld_q || out_load);
    wr_ptr_d  = do_wr  ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d  = ram_rd ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    mid_vld_d = ram_rd || (mid_vld_q && !out_load);
    rd_vld_d  = out_load ? mid_vld_q : rd_vld_q;
    count_d   = count_q + cnt_t'(do_wr) - cnt_t'(do_pop);
    ovf_d     = ovf_q || (bus.wr_en && !wr_vld_q);
    udf_d     = udf_q || (bus.rd_en && !rd_vld_q);
    if (bus.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      mid_vld_d = 1'b0;
      rd_vld_d  = 1'b0;
      count_d   = '0;
      ovf_d     = 1'b0;
      udf_d     = 1'b0;
    end
    wr_vld_d = count_d < DEPTH_C;
    afull_d  = count_d >= AFULL_C;
  end

  // Control stage: pointers, occupancy, valids, status flags and the output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mid_vld_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_vld_q  <= 1'b1;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mid_vld_q <= mid_vld_d;
      rd_vld_q  <= rd_vld_d;
      wr_vld_q  <= wr_vld_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      if (out_load && mid_vld_q) rd_data_q <= mid_data_q;
    end
  end

  // RAM stage: write port and registered read port, no reset on storage.
  always_ff @(posedge clk) begin
    if (do_wr && rst && !bus.flush) mem_q[wr_ptr_q] <= bus.wr_data;
    if (ram_rd) mid_data_q <= mem_q[rd_ptr_q];
  end

`ifdef STORE_ADDR_FIFO_PEAK_EN
  cnt_t peak_q;
  always_ff @(posedge clk) begin
    if (!rst || bus.flush) peak_q <= '0;
    else if (count_d > peak_q) peak_q <= count_d;
  end
  assign bus.peak = peak_q;
`endif

  assign bus.wr_vld  = wr_vld_q;
  assign bus.afull   = afull_q;
  assign bus.rd_data = rd_data_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.count   = count_q;
  assign bus.ovf     = ovf_q;
  assign bus.udf     = udf_q;
endmodule

// File: tb/tb_store_addr_prefetch_fifo.sv
// Scoreboard bench for store_addr_prefetch_fifo at DATA_WIDTH=4, DEPTH_WIDTH=4, AFULL_TH=12.
// Accepted writes are queued with their write edge; the head is expected valid two edges after its write.
module tb_store_addr_prefetch_fifo;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int ATH = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  store_addr_prefetch_fifo_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW)) bus ();

  store_addr_prefetch_fifo #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .AFULL_TH(ATH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            w;
  } ent_t;

  ent_t q[$];
  int   edge_n  = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;
  bit   ovf_m   = 0;
  bit   udf_m   = 0;
  int   peak_m  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit front_vld();
    return (q.size() > 0) && ((edge_n - q[0].w) >= 3);
  endfunction

  task automatic cycle(input logic r_n, input logic fl, input logic we,
                       input logic [DW-1:0] wd, input logic re);
    bit   vpre, acc;
    ent_t x;
    rst         = r_n;
    bus.flush   = fl;
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
    vpre = front_vld();
    @(posedge clk);
    #1;
    if (!r_n || fl) begin
      q.delete();
      ovf_m  = 0;
      udf_m  = 0;
      peak_m = 0;
    end else begin
      acc = we && (q.size() < DEPTH);
      if (re && !vpre) udf_m = 1;
      if (we && !acc)  ovf_m = 1;
      if (re && vpre)  void'(q.pop_front());
      if (acc) begin
        x.d = wd;
        x.w = edge_n;
        q.push_back(x);
      end
      if (q.size() > peak_m) peak_m = q.size();
    end
    edge_n++;
    chk("count",  32'(bus.count),  32'(q.size()));
    chk("wr_vld", 32'(bus.wr_vld), 32'(q.size() < DEPTH));
    chk("afull",  32'(bus.afull),  32'(q.size() >= ATH));
    chk("rd_vld", 32'(bus.rd_vld), 32'(front_vld()));
    chk("ovf",    32'(bus.ovf),    32'(ovf_m));
    chk("udf",    32'(bus.udf),    32'(udf_m));
    if (front_vld()) chk("rd_data", 32'(bus.rd_data), 32'(q[0].d));
    if (!r_n) chk("rd_data_rst", 32'(bus.rd_data), 32'h0);
`ifdef STORE_ADDR_FIFO_PEAK_EN
    chk("peak", 32'(bus.peak), 32'(peak_m));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // Reset, with requests asserted that must be ignored
    cycle(1'b0, 1'b0, 1'b1, 4'h3, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Single write, visible two edges later, then pop it
    cycle(1'b1, 1'b0, 1'b1, 4'hA, 1'b0);
    chk("single_cnt", 32'(bus.count), 32'd1);
    chk("single_vld_e0", 32'(bus.rd_vld), 32'd0);
    idle(1);
    chk("single_vld_e1", 32'(bus.rd_vld), 32'd0);
    idle(1);
    chk("single_vld_e2", 32'(bus.rd_vld), 32'd1);
    chk("single_data", 32'(bus.rd_data), 32'hA);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

    // Fill to full, overflow attempt, then drain one per cycle
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i), 1'b0);
    chk("full_wr_vld", 32'(bus.wr_vld), 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 4'h5, 1'b0);
    chk("full_ovf", 32'(bus.ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("drained", 32'(bus.count), 32'd0);

    // Full with simultaneous write and pop, then a write is accepted
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b1, 4'(15 - i), 1'b0);
    idle(2);
    cycle(1'b1, 1'b0, 1'b1, 4'h7, 1'b1);
    chk("fullrw_cnt", 32'(bus.count), 32'd15);
    chk("fullrw_ovf", 32'(bus.ovf), 32'd1);
    cycle(1'b1, 1'b0, 1'b1, 4'h9, 1'b0);
    chk("fullrw_refill", 32'(bus.count), 32'd16);

    // Steady simultaneous write/pop at count 3 across pointer wraps
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i + 1), 1'b0);
    idle(2);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'b1, 4'($urandom_range(15)), 1'b1);
    chk("steady_cnt", 32'(bus.count), 32'd3);

    // Underflow on empty, then flush at count 7
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    chk("udf_set", 32'(bus.udf), 32'd1);
    chk("udf_cnt", 32'(bus.count), 32'd0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 4'hF, 1'b1);
    chk("flush_cnt", 32'(bus.count), 32'd0);
    chk("flush_udf", 32'(bus.udf), 32'd0);

    // One-cycle reset at count 9
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, 4'(i + 6), 1'b0);
`ifdef STORE_ADDR_FIFO_PEAK_EN
    chk("peak_pre_rst", 32'(bus.peak), 32'd9);
`endif
    cycle(1'b0, 1'b0, 1'b1, 4'h1, 1'b1);
    chk("rst_cnt", 32'(bus.count), 32'd0);
    chk("rst_wr_vld", 32'(bus.wr_vld), 32'd1);

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++)
      cycle(1'b1, 1'($urandom_range(63) == 0), 1'($urandom_range(9) < 6),
            4'($urandom_range(15)), 1'($urandom_range(9) < 5));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_addr_prefetch_fifo.md
STORE_ADDR_PREFETCH_FIFO -- requirements
Module: store_addr_prefetch_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 4: entry width in bits, legal 1..1152.
REQ-002 Parameter DEPTH_WIDTH, default 11: capacity DEPTH = 2**DEPTH_WIDTH entries, legal 2..20.
REQ-003 Parameter AFULL_TH, default 2**DEPTH_WIDTH-4: almost-full threshold in entries, legal 1..DEPTH.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  synchronous discard of all stored entries.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_WIDTH  write data.
REQ-009 wr_vld  output  1  write accepted this cycle if wr_en is high (not full).
REQ-010 afull  output  1  count >= AFULL_TH.
REQ-011 rd_en  input  1  pop request for the presented entry.
REQ-012 rd_data  output  DATA_WIDTH  head entry, valid while rd_vld is high (first-word-fall-through).
REQ-013 rd_vld  output  1  rd_data holds a valid head entry.
REQ-014 count  output  DEPTH_WIDTH+1  entries written and not yet popped.
REQ-015 ovf  output  1  sticky: write attempted while full.
REQ-016 udf  output  1  sticky: pop attempted while empty.

Function
REQ-017 Storage: DEPTH-entry RAM with registered read plus one prefetch output register; total capacity (RAM + output register) SHALL equal DEPTH exactly.
REQ-018 Write occurs iff wr_en && wr_vld; wr_vld SHALL be high iff count < DEPTH.
REQ-019 Pop occurs iff rd_en && rd_vld; after a pop, rd_data SHALL advance to the next entry in the following cycle with no bubble when at least one further entry was stored two or more cycles earlier.
REQ-020 Latency: a word written at edge N into an empty FIFO SHALL present rd_vld=1 with that word after edge N+2; no same-cycle write-to-read bypass.
REQ-021 count SHALL update on the edge of the operation: +1 write only, -1 pop only, unchanged for simultaneous write and pop.
REQ-022 Full with simultaneous wr_en and rd_en: pop proceeds, write is rejected (wr_vld was low), ovf sets.
REQ-023 wr_en while wr_vld low: data dropped, contents unchanged, ovf set to 1 until reset or flush.
REQ-024 rd_en while rd_vld low: ignored, udf set to 1 until reset or flush.
REQ-025 Pointers SHALL be DEPTH_WIDTH bits and wrap modulo DEPTH without loss or duplication.
REQ-026 flush SHALL take priority over wr_en and rd_en in the same cycle; after that edge count=0, rd_vld=0, wr_vld=1, afull=0, ovf=0, udf=0; RAM contents need not be cleared.
REQ-027 afull SHALL be registered, consistent with count on the same cycle.

Reset
REQ-028 While rst=0 at a clock edge: pointers and count to 0, rd_vld=0, rd_data=0, wr_vld=1 from the first cycle after reset, afull=0, ovf=0, udf=0.
REQ-029 Reset mid-operation SHALL discard all entries; wr_en/rd_en asserted during reset SHALL have no effect.

Configuration
REQ-030 Macro STORE_ADDR_FIFO_PEAK_EN: when defined, adds output peak [DEPTH_WIDTH:0] holding the maximum count since reset or flush (cleared to 0 by both, updated the edge count rises).
REQ-031 Without STORE_ADDR_FIFO_PEAK_EN the peak port and its register SHALL not exist; all other behaviour identical.

Verification (DATA_WIDTH=4, DEPTH_WIDTH=4, AFULL_TH=12)
REQ-032 Single write 0xA into empty FIFO at edge 0 -> rd_vld=1, rd_data=0xA after edge 2; count=1 after edge 0.
REQ-033 16 back-to-back writes 0x0..0xF -> wr_vld=0 and count=16 after 16th write, afull=1 from count=12; 17th write 0x5 -> dropped, ovf=1; 16 pops return 0x0..0xF in order, one per cycle.
REQ-034 Full, wr_en and rd_en together -> pop returns head, count=15, ovf=1; next cycle write accepted, count=16.
REQ-035 Continuous simultaneous write/pop over 40 cycles at count=3 -> count stays 3, pointers wrap twice, data order preserved.
REQ-036 rd_en on empty -> udf=1, count=0; then flush while count=7 -> count=0, rd_vld=0, ovf=udf=0 next cycle.
REQ-037 rst=0 for one cycle at count=9 -> count=0, rd_vld=0, wr_vld=1; with STORE_ADDR_FIFO_PEAK_EN, peak=9 before reset and 0 after.
